fifo_sync_thr: RTL and testbench
================================

// Module: fifo_sync_thr
// PURPOSE
//  Parametrised synchronous FIFO with an internal memory array and push/pop control.
//  Adds programmable almost-full/almost-empty thresholds, an occupancy output,
//  a sticky overflow/underflow error and a compile-time first-word-fall-through mode.
//  Sits between producer and consumer stages of the datapath as the generic elastic buffer.
// PARAMETERS
//  DATA_WIDTH  10  bits per word
//  ADDR_WIDTH  3   pointer width; depth D = 2**ADDR_WIDTH (default 8 words)
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  reset         in   1             synchronous, active-low (0 = reset)
//  push          in   1             write request, data_in valid this cycle
//  data_in       in   DATA_WIDTH    write data
//  pop           in   1             read request
//  thr_af        in   ADDR_WIDTH+1  almost-full threshold (occupancy)
//  thr_ae        in   ADDR_WIDTH+1  almost-empty threshold (occupancy)
//  data_out      out  DATA_WIDTH    read data
//  valid_out     out  1             data_out carries a popped word (see mode)
//  count         out  ADDR_WIDTH+1  current occupancy, 0..D
//  full          out  1             count == D
//  empty         out  1             count == 0
//  almost_full   out  1             count >= thr_af
//  almost_empty  out  1             count <= thr_ae
//  error         out  1             sticky: overflow or underflow seen since reset
// BEHAVIOUR
//  - Reset (reset==0 at posedge): wr_ptr, rd_ptr, count, error, valid_out, data_out <= 0.
//    Memory contents not cleared. Mid-operation reset discards all words. empty=1 and
//    almost_empty=1 (for any thr_ae) are visible the cycle after the reset edge.
//  - pop_acc  = pop & ~empty.  push_acc = push & (~full | pop_acc).
//  - push_acc: mem[wr_ptr] <= data_in; wr_ptr++ (wraps modulo D, no special case).
//  - pop_acc: rd_ptr++ (wraps modulo D).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Full and simultaneous push+pop: both accepted, count stays D.
//  - Empty and simultaneous push+pop: push accepted, pop rejected = underflow.
//  - Overflow: push & full & ~pop_acc -> word dropped, state unchanged, error <= 1.
//  - Underflow: pop & empty -> no pointer change, data_out holds, error <= 1.
//  - error clears only by reset.
//  - full/empty/almost_* are combinational from count and thresholds. Thresholds are
//    sampled live: changing them changes the flags in the same cycle.
//    thr_af=0 -> almost_full always 1. thr_ae>=D -> almost_empty always 1.
// CONFIGURATION
//  FIFO_FWFT_EN undefined (default, registered read):
//    on pop_acc, data_out <= mem[rd_ptr] and valid_out <= 1 one cycle later.
//    Otherwise valid_out <= 0 and data_out holds its last value. Read latency is 1 cycle.
//  FIFO_FWFT_EN defined (first-word fall-through):
//    data_out = mem[rd_ptr] combinationally and valid_out = ~empty.
//    pop acts as the acknowledge, so the head word is visible with 0 latency.
//    The write-to-visible path is 1 cycle after push_acc into an empty FIFO.
//  Counters, flags and error behave identically in both modes.
// TESTING
//  1 Fill/drain: push 8 words 0x001..0x008, then pop 8 -> full=1 after the 8th push,
//    count=8; pops return 0x001..0x008 in order; empty=1 and count=0 at end; error=0.
//  2 Overflow: with the FIFO full, push 0x3FF without pop -> count stays 8, error=1,
//    and 0x3FF never appears on data_out.
//  3 Underflow: after reset, pop -> error=1, valid_out=0, count=0, rd_ptr unchanged.
//  4 Simultaneous ops: at count=8, push 0x055 with pop -> count=8, error=0, 0x055 read
//    last. On empty, push+pop -> count=1, error=1.
//  5 Thresholds: thr_af=6, thr_ae=2; push 6 words -> almost_empty drops at count=3,
//    almost_full rises at count=6; thr_af set to 7 -> almost_full falls the same cycle.
//  6 Wrap/reset: 20 interleaved push/pop cycles cross the pointer wrap with data intact.
//    reset=0 at count=5 -> count=0, empty=1, error=0 next cycle.
//    Repeat scenarios 1 and 4 with FIFO_FWFT_EN defined.

Source files
------------

// File: rtl/fifo_sync_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, occupancy and sticky error.
// Define FIFO_FWFT_EN for first-word fall-through reads; the default build uses a registered read.
module fifo_sync_thr #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   thr_af,
    input  logic [ADDR_WIDTH:0]   thr_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  error_q, error_d;
    logic                  full_s, empty_s;
    logic                  pop_acc_s, push_acc_s;
    logic                  overflow_s, underflow_s;

    // Status flags and handshake acceptance, all derived from the registered occupancy.
    always_comb begin
        full_s       = (count_q == DEPTH_C);
        empty_s      = (count_q == {(ADDR_WIDTH + 1){1'b0}});
        pop_acc_s    = pop & ~empty_s;
        push_acc_s   = push & (~full_s | pop_acc_s);
        overflow_s   = push & full_s & ~pop_acc_s;
        underflow_s  = pop & empty_s;
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_q >= thr_af);
        almost_empty = (count_q <= thr_ae);
        count        = count_q;
        error        = error_q;
    end

    // Next-state for pointers, occupancy and the sticky error bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q;
        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_acc_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
        if (overflow_s || underflow_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q <= {ADDR_WIDTH{1'b0}};
            count_q  <= {(ADDR_WIDTH + 1){1'b0}};
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (reset && push_acc_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is exposed directly; pop only acknowledges it.
    always_comb begin
        data_out  = mem_q[rd_ptr_q];
        valid_out = ~empty_s;
    end
`else
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    // Registered read: capture the head word on an accepted pop, otherwise hold.
    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (pop_acc_s) begin
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end else begin
            data_out_d  = data_out_q;
            valid_out_d = 1'b0;
        end
    end

    // Read output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_q  <= {DATA_WIDTH{1'b0}};
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Drive ports from the read register.
    always_comb begin
        data_out  = data_out_q;
        valid_out = valid_out_q;
    end
`endif

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Directed scoreboard bench for fifo_sync_thr; follows FIFO_FWFT_EN if it is defined.
module tb_fifo_sync_thr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [9:0] data_in = 10'd0;
    logic       pop = 1'b0;
    logic [3:0] thr_af = 4'd6;
    logic [3:0] thr_ae = 4'd2;
    logic [9:0] data_out;
    logic       valid_out;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, error;

    int         vecs = 0;
    int         fails = 0;
    logic [9:0] sb[$];
    int         cnt_m = 0;
    logic       err_m = 1'b0;
    logic [9:0] last_m = 10'd0;

    fifo_sync_thr #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .thr_af(thr_af), .thr_ae(thr_ae), .data_out(data_out), .valid_out(valid_out),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 16'(count), 16'(cnt_m));
        chk({tag, ".full"}, 16'(full), 16'(cnt_m == 8));
        chk({tag, ".empty"}, 16'(empty), 16'(cnt_m == 0));
        chk({tag, ".error"}, 16'(error), 16'(err_m));
        chk({tag, ".af"}, 16'(almost_full), 16'(cnt_m >= int'(thr_af)));
        chk({tag, ".ae"}, 16'(almost_empty), 16'(cnt_m <= int'(thr_ae)));
    endtask

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input logic p, input logic [9:0] d, input logic q, input string tag);
        logic       pop_acc, push_acc;
        logic [9:0] exp;
        pop_acc  = q && (cnt_m > 0);
        push_acc = p && ((cnt_m < 8) || pop_acc);
        exp      = 10'd0;
        if (pop_acc) exp = sb.pop_front();
        push = p; data_in = d; pop = q;
        #1;
`ifdef FIFO_FWFT_EN
        chk({tag, ".valid"}, 16'(valid_out), 16'(cnt_m > 0));
        if (pop_acc) chk({tag, ".data"}, 16'(data_out), 16'(exp));
`endif
        @(posedge clk);
        #1;
        if (push_acc) sb.push_back(d);
        if ((p && !push_acc) || (q && cnt_m == 0)) err_m = 1'b1;
        if (push_acc && !pop_acc) cnt_m++;
        else if (pop_acc && !push_acc) cnt_m--;
`ifndef FIFO_FWFT_EN
        chk({tag, ".valid"}, 16'(valid_out), 16'(pop_acc));
        if (pop_acc) last_m = exp;
        chk({tag, ".data"}, 16'(data_out), 16'(last_m));
`endif
        chk_state(tag);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cnt_m = 0; err_m = 1'b0; last_m = 10'd0;
        sb.delete();
        chk_state(tag);
        chk({tag, ".valid"}, 16'(valid_out), 16'd0);
`ifndef FIFO_FWFT_EN
        chk({tag, ".data"}, 16'(data_out), 16'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // Fill and drain
        for (int i = 1; i <= 8; i++) step(1'b1, 10'(i), 1'b0, "fill");
        for (int i = 0; i < 8; i++) step(1'b0, 10'd0, 1'b1, "drain");
        step(1'b0, 10'd0, 1'b0, "idle");
        chk("drain.sb_empty", 16'(sb.size()), 16'd0);

        // Overflow: 0x3FF must never be read back
        for (int i = 1; i <= 8; i++) step(1'b1, 10'(16 + i), 1'b0, "ofill");
        step(1'b1, 10'h3FF, 1'b0, "overflow");
        for (int i = 0; i < 8; i++) step(1'b0, 10'd0, 1'b1, "odrain");

        // Underflow straight after reset, then data path still aligned
        do_reset("rst1");
        step(1'b0, 10'd0, 1'b1, "underflow");
        step(1'b1, 10'h123, 1'b0, "uf_push");
        step(1'b0, 10'd0, 1'b1, "uf_pop");

        // Simultaneous push+pop at full and at empty
        do_reset("rst2");
        for (int i = 1; i <= 8; i++) step(1'b1, 10'(32 + i), 1'b0, "sfill");
        step(1'b1, 10'h055, 1'b1, "full_pp");
        for (int i = 0; i < 8; i++) step(1'b0, 10'd0, 1'b1, "sdrain");
        step(1'b1, 10'h0AA, 1'b1, "empty_pp");
        step(1'b0, 10'd0, 1'b1, "empty_pp_rd");

        // Thresholds, including live changes within a cycle
        do_reset("rst3");
        thr_af = 4'd6; thr_ae = 4'd2;
        for (int i = 1; i <= 6; i++) step(1'b1, 10'(64 + i), 1'b0, "thr");
        thr_af = 4'd7;
        #1;
        chk("thr_af7", 16'(almost_full), 16'd0);
        thr_af = 4'd0;
        #1;
        chk("thr_af0", 16'(almost_full), 16'd1);
        thr_ae = 4'd8;
        #1;
        chk("thr_ae8", 16'(almost_empty), 16'd1);
        thr_af = 4'd6; thr_ae = 4'd2;
        @(negedge clk);

        // Interleaved traffic across the pointer wrap, then mid-operation reset
        do_reset("rst4");
        for (int i = 0; i < 3; i++) step(1'b1, 10'(128 + i), 1'b0, "wpre");
        for (int i = 0; i < 20; i++)
            step(1'b1, 10'($urandom_range(0, 1023)), 1'b1, "wrap");
        step(1'b1, 10'h200, 1'b0, "w5a");
        step(1'b1, 10'h201, 1'b0, "w5b");
        chk("w5.count", 16'(count), 16'd5);
        do_reset("rst5");
        step(1'b1, 10'h2AB, 1'b0, "post_push");
        step(1'b0, 10'd0, 1'b1, "post_pop");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
